// File: rtl/if_fetch_queue.sv
// In-order instruction prefetcher feeding a DEPTH-entry decode queue; every request owns a slot.
// Define IF_MISALIGN_CHECK_EN to turn misaligned redirects into a queued fetch exception (id_exc).
module if_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        id_valid,
    output logic [31:0] id_instruction,
    output logic [31:0] id_pc
`ifdef IF_MISALIGN_CHECK_EN
    ,
    output logic        id_exc
`endif
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam logic [CntW:0] DepthLim = (CntW + 1)'(DEPTH);

    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     resp_pc_q, resp_pc_d;
    logic [CntW-1:0] outstanding_q, outstanding_d;
    logic [CntW-1:0] drop_q, drop_d;
    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;

    logic [31:0] q_instr [DEPTH];
    logic [31:0] q_pc    [DEPTH];

    logic            wr_en;
    logic [PtrW-1:0] wr_idx;
    logic [31:0]     wr_instr;
    logic [31:0]     wr_pc;

    logic issue_ok;
    logic do_grant;
    logic do_deq;
    logic ack_any;
    logic ack_keep;

`ifdef IF_MISALIGN_CHECK_EN
    logic q_exc [DEPTH];
    logic hold_q, hold_d;
    logic wr_exc;
`else
    logic unused_rpc_lsbs;
    assign unused_rpc_lsbs = ^redirect_pc[1:0];
`endif

    // Reserve a queue slot per request, and never exceed DEPTH responses still owed by memory.
    always_comb begin
        issue_ok = (({1'b0, outstanding_q} + {1'b0, count_q}) < DepthLim) &&
                   (({1'b0, drop_q} + {1'b0, outstanding_q}) < DepthLim);
`ifdef IF_MISALIGN_CHECK_EN
        issue_ok = issue_ok && !hold_q;
`endif
        imem_req  = rst && !redirect && issue_ok;
        imem_addr = fetch_pc_q;
    end

    always_comb begin
        do_grant = imem_req && imem_gnt;
        do_deq   = id_valid && !stall;
        ack_any  = imem_ack && ((drop_q != '0) || (outstanding_q != '0));
        ack_keep = ack_any && (drop_q == '0);

        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        wr_en         = 1'b0;
        wr_idx        = wr_ptr_q;
        wr_instr      = imem_rdata;
        wr_pc         = resp_pc_q;
`ifdef IF_MISALIGN_CHECK_EN
        hold_d        = hold_q;
        wr_exc        = 1'b0;
`endif

        if (redirect) begin
            // Everything in flight becomes garbage; an ack this cycle already retires one of it.
            fetch_pc_d    = {redirect_pc[31:2], 2'b00};
            resp_pc_d     = {redirect_pc[31:2], 2'b00};
            outstanding_d = '0;
            drop_d        = drop_q + outstanding_q - CntW'(ack_any);
            count_d       = '0;
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
`ifdef IF_MISALIGN_CHECK_EN
            hold_d = (redirect_pc[1:0] != 2'b00);
            if (hold_d) begin
                wr_en    = 1'b1;
                wr_idx   = '0;
                wr_instr = '0;
                wr_pc    = redirect_pc;
                wr_exc   = 1'b1;
                wr_ptr_d = PtrW'(1);
                count_d  = CntW'(1);
            end
`endif
        end else begin
            if (do_grant) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (ack_any && !ack_keep) begin
                drop_d = drop_q - CntW'(1);
            end
            if (ack_keep) begin
                wr_en     = 1'b1;
                wr_ptr_d  = wr_ptr_q + PtrW'(1);
                resp_pc_d = resp_pc_q + 32'd4;
            end
            if (do_deq) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            outstanding_d = outstanding_q + CntW'(do_grant) - CntW'(ack_keep);
            count_d       = count_q + CntW'(ack_keep) - CntW'(do_deq);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
`ifdef IF_MISALIGN_CHECK_EN
            hold_q        <= 1'b0;
`endif
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
`ifdef IF_MISALIGN_CHECK_EN
            hold_q        <= hold_d;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
`ifdef IF_MISALIGN_CHECK_EN
                q_exc[i]   <= 1'b0;
`endif
            end
        end else if (wr_en) begin
            q_instr[wr_idx] <= wr_instr;
            q_pc[wr_idx]    <= wr_pc;
`ifdef IF_MISALIGN_CHECK_EN
            q_exc[wr_idx]   <= wr_exc;
`endif
        end
    end

    always_comb begin
        id_valid       = (count_q != '0);
        id_instruction = id_valid ? q_instr[rd_ptr_q] : '0;
        id_pc          = id_valid ? q_pc[rd_ptr_q] : '0;
`ifdef IF_MISALIGN_CHECK_EN
        id_exc         = id_valid && q_exc[rd_ptr_q];
`endif
    end

endmodule
